// File: rtl/ysyx_23060077_ifetch_mem_resp.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_23060077_ifetch_mem_resp
// Brief   : I-cache refill burst engine; issues one word read at a time to
//           the backing memory and returns each beat with a registered pulse.
//           Define YSYX_23060077_IFETCH_WRAP_EN for critical-word-first
//           wrapping bursts (len+1 must be a power of two).
// Revision: 1.0
// ============================================================================
module ysyx_23060077_ifetch_mem_resp #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Icache_r_valid_i,
    input  logic [ADDR_W-1:0] Icache_r_addr_i,
    input  logic [LEN_W-1:0]  Icache_r_len_i,
    output logic              Icache_r_ready_o,
    output logic [DATA_W-1:0] Icache_r_data_o,
    output logic              Icache_r_last_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int                c_STRIDE   = DATA_W / 8;
    localparam logic [ADDR_W-1:0] c_STRIDE_A = ADDR_W'(c_STRIDE);
    localparam logic [ADDR_W-1:0] c_OFF_MASK = ADDR_W'(c_STRIDE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W:0]     r_cnt;
    logic [DATA_W-1:0]  r_data;
    logic               r_ready;
    logic               r_last;
    logic               w_final;

    // Counter is one bit wider than len so a maximal burst never wraps it.
    assign w_final = (r_cnt == {1'b0, r_len});

`ifdef YSYX_23060077_IFETCH_WRAP_EN
    localparam int                c_OFF_W = $clog2(c_STRIDE);
    localparam logic [ADDR_W-1:0] c_ONE   = ADDR_W'(1);
    logic [ADDR_W-1:0] w_blk_mask;
    logic [ADDR_W-1:0] w_addr_inc;

    // Block of (len+1) beats; only the in-block offset advances.
    assign w_blk_mask = ((ADDR_W'({1'b0, r_len}) + c_ONE) << c_OFF_W) - c_ONE;
    assign w_addr_inc = r_addr + c_STRIDE_A;
    assign w_addr_nxt = (r_addr & ~w_blk_mask) | (w_addr_inc & w_blk_mask);
`else
    assign w_addr_nxt = r_addr + c_STRIDE_A;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (Icache_r_valid_i) w_state_nxt = S_REQ;
            S_REQ:  if (mem_gnt_i)        w_state_nxt = S_WAIT;
            S_WAIT: if (mem_rvalid_i)     w_state_nxt = w_final ? S_DONE : S_REQ;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_ready <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_last  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Icache_r_valid_i) begin
                        r_addr <= Icache_r_addr_i & ~c_OFF_MASK;
                        r_len  <= Icache_r_len_i;
                        r_cnt  <= '0;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        r_data  <= mem_rdata_i;
                        r_ready <= 1'b1;
                        r_last  <= w_final;
                        if (!w_final) begin
                            r_cnt  <= r_cnt + (LEN_W + 1)'(1);
                            r_addr <= w_addr_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign Icache_r_ready_o = r_ready;
    assign Icache_r_last_o  = r_last;
    assign Icache_r_data_o  = r_data;
    assign mem_req_o        = (r_state == S_REQ);
    assign mem_addr_o       = r_addr;

endmodule
`default_nettype wire
